// File: rtl/regfile_pkg.sv
// Shared widths and index/data types for the scoreboarded register file.
package regfile_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Write, read and claim signals of the register file, bundled for the bench and the array.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_RD_PORTS = 2
);
    logic                                     i_we;
    logic [ADDR_WIDTH-1:0]                    i_wr_address;
    logic [DATA_WIDTH-1:0]                    i_wr_data;
    logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]  i_rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  o_rd_data;
    logic [NUM_RD_PORTS-1:0]                  o_rd_busy;
    logic                                     i_claim_valid;
    logic [ADDR_WIDTH-1:0]                    i_claim_addr;
    logic                                     o_claim_ready;
    logic [ADDR_WIDTH:0]                      o_busy_count;

    modport master (
        output i_we, i_wr_address, i_wr_data, i_rd_addr, i_claim_valid, i_claim_addr,
        input  o_rd_data, o_rd_busy, o_claim_ready, o_busy_count
    );

    modport slave (
        input  i_we, i_wr_address, i_wr_data, i_rd_addr, i_claim_valid, i_claim_addr,
        output o_rd_data, o_rd_busy, o_claim_ready, o_busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits, claim handshake and registered busy population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_we,
    input  logic [ADDR_WIDTH-1:0]                   i_wr_address,
    input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                                    i_claim_valid,
    input  logic [ADDR_WIDTH-1:0]                   i_claim_addr,
    output logic [NUM_RD_PORTS-1:0]                 o_rd_busy,
    output logic                                    o_claim_ready,
    output logic [ADDR_WIDTH:0]                     o_busy_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_WIDTH:0] r_count;
    logic [ADDR_WIDTH:0] w_count_nxt;
    logic              w_claim_ready;
    logic              w_claim_acc;

    // Write clears first so a same-cycle claim of the same register keeps it busy.
    always_comb begin
        w_claim_ready = !(r_busy[i_claim_addr] && !(i_we && (i_wr_address == i_claim_addr)));
        w_claim_acc   = i_claim_valid && w_claim_ready;
        w_busy_nxt    = r_busy;
        if (i_we) begin
            w_busy_nxt[i_wr_address] = 1'b0;
        end
        if (w_claim_acc) begin
            w_busy_nxt[i_claim_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
        w_count_nxt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_nxt = w_count_nxt + {{ADDR_WIDTH{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_comb begin
        o_rd_busy = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            o_rd_busy[p] = r_busy[i_rd_addr[p]]
                           && (i_rd_addr[p] != '0)
                           && !((BYPASS != 0) && i_we && (i_wr_address == i_rd_addr[p]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_claim_ready = w_claim_ready;
    assign o_busy_count  = r_count;
endmodule

// File: rtl/regfile_sb.sv
// Register file with zero-latency reads, optional write forwarding and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]                   r_mem [DEPTH];
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_RD_PORTS-1:0]                 w_rd_busy;
    logic                                    w_claim_ready;
    logic [ADDR_WIDTH:0]                     w_busy_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.i_we && (bus.i_wr_address != '0)) begin
            r_mem[bus.i_wr_address] <= bus.i_wr_data;
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (bus.i_rd_addr[p] == '0) begin
                w_rd_data[p] = '0;
            end else if ((BYPASS != 0) && bus.i_we && (bus.i_wr_address == bus.i_rd_addr[p])) begin
                w_rd_data[p] = bus.i_wr_data;
            end else begin
                w_rd_data[p] = r_mem[bus.i_rd_addr[p]];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .BYPASS       (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_we          (bus.i_we),
        .i_wr_address  (bus.i_wr_address),
        .i_rd_addr     (bus.i_rd_addr),
        .i_claim_valid (bus.i_claim_valid),
        .i_claim_addr  (bus.i_claim_addr),
        .o_rd_busy     (w_rd_busy),
        .o_claim_ready (w_claim_ready),
        .o_busy_count  (w_busy_count)
    );

    assign bus.o_rd_data     = w_rd_data;
    assign bus.o_rd_busy     = w_rd_busy;
    assign bus.o_claim_ready = w_claim_ready;
    assign bus.o_busy_count  = w_busy_count;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: forwarding and non-forwarding instances share stimulus and one array model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP)) bus ();
    regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP)) bus_nb ();

    assign bus_nb.i_we          = bus.i_we;
    assign bus_nb.i_wr_address  = bus.i_wr_address;
    assign bus_nb.i_wr_data     = bus.i_wr_data;
    assign bus_nb.i_rd_addr     = bus.i_rd_addr;
    assign bus_nb.i_claim_valid = bus.i_claim_valid;
    assign bus_nb.i_claim_addr  = bus.i_claim_addr;

    regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP), .BYPASS(0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_nb.slave)
    );

    // reference model: plain array contents and a set of busy registers
    reg_data_t m_mem [32];
    bit        m_busy [32];

    logic           t_we, t_cv, t_rst;
    logic [AW-1:0]  t_wa, t_ca, t_ra0, t_ra1;
    logic [DW-1:0]  t_wd;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && t_we && t_wa == a) return t_wd;
        return m_mem[a];
    endfunction

    function automatic logic m_rd_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && t_we && t_wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic m_ready();
        return !(m_busy[t_ca] && !(t_we && t_wa == t_ca));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                          input logic cv, input logic [AW-1:0] ca, input logic rs);
        t_we = we; t_wa = wa; t_wd = wd; t_ra0 = ra0; t_ra1 = ra1;
        t_cv = cv; t_ca = ca; t_rst = rs;
        rst               = rs;
        bus.i_we          = we;
        bus.i_wr_address  = wa;
        bus.i_wr_data     = wd;
        bus.i_rd_addr[0]  = ra0;
        bus.i_rd_addr[1]  = ra1;
        bus.i_claim_valid = cv;
        bus.i_claim_addr  = ca;
    endtask

    task automatic check_model();
        logic [AW-1:0] a;
        for (int p = 0; p < NP; p++) begin
            a = (p == 0) ? t_ra0 : t_ra1;
            chk($sformatf("rd_data_byp[%0d] a=%0d", p, a), 64'(bus.o_rd_data[p]), 64'(m_read(a, 1'b1)));
            chk($sformatf("rd_data_nob[%0d] a=%0d", p, a), 64'(bus_nb.o_rd_data[p]), 64'(m_read(a, 1'b0)));
            chk($sformatf("rd_busy_byp[%0d] a=%0d", p, a), 64'(bus.o_rd_busy[p]), 64'(m_rd_busy(a, 1'b1)));
            chk($sformatf("rd_busy_nob[%0d] a=%0d", p, a), 64'(bus_nb.o_rd_busy[p]), 64'(m_rd_busy(a, 1'b0)));
        end
        chk("claim_ready", 64'(bus.o_claim_ready), 64'(m_ready()));
        chk("claim_ready_nob", 64'(bus_nb.o_claim_ready), 64'(m_ready()));
        chk("busy_count", 64'(bus.o_busy_count), 64'(m_count()));
        chk("busy_count_nob", 64'(bus_nb.o_busy_count), 64'(m_count()));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic cv, input logic [AW-1:0] ca, input logic rs);
        set_in(we, wa, wd, ra0, ra1, cv, ca, rs);
        #1;
        check_model();
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (t_rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            acc = t_cv && m_ready();
            if (t_we && t_wa != 0) begin
                m_mem[t_wa]  = t_wd;
                m_busy[t_wa] = 1'b0;
            end
            if (acc && t_ca != 0) m_busy[t_ca] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        set_in(1'b1, 5'd3, 32'h1234, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1);
        tick();

        // post-reset: everything reads zero and claims are accepted
        drive(1'b0, 5'd0, '0, 5'd17, 5'd31, 1'b0, 5'd12, 1'b0);
        chk("post_rst_rd", 64'(bus.o_rd_data[1]), 64'h0);
        chk("post_rst_ready", 64'(bus.o_claim_ready), 64'h1);
        tick();

        for (int i = 0; i < 32; i++) begin
            drive(1'b1, AW'(i), DW'(i + 1), AW'($urandom_range(31)), AW'(i), 1'b0, 5'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 32; i += 2) begin
            drive(1'b0, 5'd0, '0, AW'(i), AW'(i + 1), 1'b0, 5'd0, 1'b0);
            chk($sformatf("fill_rd r%0d", i), 64'(bus.o_rd_data[0]), (i == 0) ? 64'h0 : 64'(i + 1));
            chk($sformatf("fill_rd r%0d", i + 1), 64'(bus.o_rd_data[1]), 64'(i + 2));
            tick();
        end

        drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0);
        chk("bypass_on", 64'(bus.o_rd_data[1]), 64'hDEADBEEF);
        chk("bypass_off", 64'(bus_nb.o_rd_data[1]), 64'h8);
        tick();

        drive(1'b0, 5'd0, '0, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
        chk("claim5_count", 64'(bus.o_busy_count), 64'h1);
        chk("claim5_rd_busy", 64'(bus.o_rd_busy[0]), 64'h1);
        chk("claim5_again_ready", 64'(bus.o_claim_ready), 64'h0);
        tick();
        drive(1'b1, 5'd5, 32'h55, 5'd5, 5'd1, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd1, 1'b0, 5'd0, 1'b0);
        chk("write5_count", 64'(bus.o_busy_count), 64'h0);
        chk("write5_rd_busy", 64'(bus.o_rd_busy[0]), 64'h0);
        tick();

        drive(1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'hA5A5_0009, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("sim9_data", 64'(bus.o_rd_data[0]), 64'hA5A5_0009);
        chk("sim9_busy", 64'(bus.o_rd_busy[0]), 64'h1);
        chk("sim9_count", 64'(bus.o_busy_count), 64'h1);
        tick();
        drive(1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();

        drive(1'b0, 5'd0, '0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0);
        chk("claim0_ready", 64'(bus.o_claim_ready), 64'h1);
        chk("claim0_rd_busy", 64'(bus.o_rd_busy[0]), 64'h0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd2, 1'b0, 5'd0, 1'b0);
        chk("claim0_count", 64'(bus.o_busy_count), 64'h0);
        tick();

        drive(1'b0, 5'd0, '0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0); tick();
        drive(1'b0, 5'd0, '0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0); tick();
        drive(1'b1, 5'd10, 32'hCAFE, 5'd6, 5'd10, 1'b1, 5'd6, 1'b0); tick();
        drive(1'b0, 5'd0, '0, 5'd3, 5'd6, 1'b0, 5'd0, 1'b0);
        chk("pre_rst_count", 64'(bus.o_busy_count), 64'h3);
        tick();
        set_in(1'b1, 5'd12, 32'hBAD0_BAD0, 5'd12, 5'd3, 1'b1, 5'd8, 1'b1);
        tick();
        for (int i = 0; i < 32; i += 2) begin
            drive(1'b0, 5'd0, '0, AW'(i), AW'(i + 1), 1'b0, 5'd0, 1'b0);
            chk($sformatf("rst_rd r%0d", i), 64'(bus.o_rd_data[0]), 64'h0);
            chk($sformatf("rst_rd r%0d", i + 1), 64'(bus.o_rd_data[1]), 64'h0);
            chk("rst_count", 64'(bus.o_busy_count), 64'h0);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(31));
            drive(1'($urandom_range(1)), wa, $urandom(),
                  ($urandom_range(3) == 0) ? wa : AW'($urandom_range(31)),
                  ($urandom_range(3) == 0) ? wa : AW'($urandom_range(31)),
                  1'($urandom_range(1)),
                  ($urandom_range(3) == 0) ? wa : AW'($urandom_range(31)),
                  ($urandom_range(60) == 0) ? 1'b1 : 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have one clock, clk, and reset, rst; reset SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register index width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the register data width.
REQ-004 Parameter NUM_RD_PORTS, default 2, range 1..4, SHALL set the read port count.
REQ-005 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-006 The ports SHALL be as follows:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_we  in  1  write enable.
- i_wr_address  in  ADDR_WIDTH  write index.
- i_wr_data  in  DATA_WIDTH  write data.
- i_rd_addr  in  NUM_RD_PORTS x ADDR_WIDTH  read indices.
- o_rd_data  out  NUM_RD_PORTS x DATA_WIDTH  read data.
- o_rd_busy  out  NUM_RD_PORTS  read register has a pending write.
- i_claim_valid  in  1  request to reserve a destination register.
- i_claim_addr  in  ADDR_WIDTH  register to reserve.
- o_claim_ready  out  1  claim accepted this cycle.
- o_busy_count  out  ADDR_WIDTH+1  number of busy registers.

Function
REQ-007 Register 0 SHALL always read 0; writes to it SHALL be ignored; it SHALL never become busy.
REQ-008 On a rising clk edge with i_we=1 and i_wr_address!=0, the array SHALL store i_wr_data at i_wr_address.
REQ-009 Reads SHALL be combinational (zero latency) from the array on every port independently.
REQ-010 With BYPASS=1, a port whose nonzero address equals i_wr_address while i_we=1 SHALL return i_wr_data in the same cycle; with BYPASS=0 it SHALL return the old array value.
REQ-011 A busy bit per register SHALL form the scoreboard.
REQ-012 A claim SHALL be handshaked: the claim is accepted when i_claim_valid=1 and o_claim_ready=1.
REQ-013 An accepted claim SHALL set the busy bit of its register at the next edge; a claim of register 0 SHALL be accepted with no effect.
REQ-014 o_claim_ready SHALL be 0 only when the claimed register is busy and is not being written this cycle.
REQ-015 A write SHALL clear the busy bit of its register at the next edge; a write to a non-busy register SHALL be a plain write.
REQ-016 When a claim and a write target the same register in the same cycle, the claim SHALL win and the busy bit SHALL remain or become 1, while the data SHALL still be written.
REQ-017 o_rd_busy[p] SHALL equal the busy bit of i_rd_addr[p], except that it SHALL be 0 for register 0 and 0 when BYPASS=1 and the register is being written this cycle.
REQ-018 o_busy_count SHALL be a registered population count of the busy bits, updated on the same edge as the busy bits, with no wrap.

Reset
REQ-019 While rst=1 at an edge, all array entries, all busy bits and o_busy_count SHALL be cleared to 0.
REQ-020 Reset SHALL take priority over a simultaneous write or claim.
REQ-021 After reset, o_rd_data SHALL be 0, o_rd_busy SHALL be 0, and o_claim_ready SHALL be 1 on all inputs.

Structure
REQ-022 Package regfile_pkg SHALL hold the default ADDR_WIDTH and DATA_WIDTH constants and the reg_idx_t and reg_data_t typedefs.
REQ-023 Busy bits, claim logic and the counter SHALL live in sub-module regfile_scoreboard; the array and bypass SHALL live in regfile_sb.

Verification
REQ-024 The bench SHALL cover fill and readback: write i+1 to registers 0..31, then read pairs -> register 0 reads 0, register i reads i+1 for i>=1.
REQ-025 The bench SHALL cover bypass: with BYPASS=1, write 0xDEADBEEF to register 7 while port 1 reads 7 -> o_rd_data[1]=0xDEADBEEF in the same cycle; with BYPASS=0 -> the old value.
REQ-026 The bench SHALL cover a claim: claim register 5 -> o_busy_count=1, o_rd_busy=1 on a port reading 5, and a second claim of 5 gives o_claim_ready=0; write register 5 -> busy clears and the count returns to 0.
REQ-027 The bench SHALL cover simultaneous events: claim 9 and write 9 in the same cycle -> data stored, register 9 still busy, count unchanged at 1.
REQ-028 The bench SHALL cover claiming register 0: claim 0 -> ready=1, count stays 0, o_rd_busy=0 for register 0.
REQ-029 The bench SHALL cover reset mid-operation: claim 3, 4 and 6 and write data, then assert rst for one cycle concurrent with a write -> all reads 0, count 0, no write landed.
